// File: rtl/lte_dp_pkg.sv
// Shared definitions for the LTE 25 us datapath monitors: FSM encoding,
// default timing constants and the expected-delay helper.
package lte_dp_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCK   = 2'd2
    } mon_state_e;

    localparam int unsigned FRAME_CYC_DEF = 12288;  // 25 us at 491.52 MHz
    localparam int unsigned X8_CYC_DEF    = 8;
    localparam int unsigned DLY_OFS_DEF   = 9;
    localparam int unsigned DLY_W         = 24;
    localparam int unsigned DATA_W        = 34;

    // Programmed delay plus the fixed pipeline offset, wrapping at 2^24.
    function automatic logic [DLY_W-1:0] exp_delay(input logic [DLY_W-1:0] set,
                                                   input int unsigned      ofs);
        return set + DLY_W'(ofs);
    endfunction

endpackage

// File: rtl/lte_delay_monitor_if.sv
// Stream, reference and status signals of the delay monitor.
interface lte_delay_monitor_if;
    import lte_dp_pkg::*;

    logic                i_fram_hd_25us;
    logic [31:0]         i_time_delay_set;
    logic                i_dly_fram_hd_25us;
    logic                i_dly_x8hd_25us;
    logic [DATA_W-1:0]   i_dly_data_25us;
    logic                i_clr;

    logic                o_fram_hd_25us;
    logic                o_x8hd_25us;
    logic [DATA_W-1:0]   o_data_25us;
    logic [DLY_W-1:0]    o_meas_delay;
    logic                o_meas_valid;
    logic                o_delay_err;
    logic                o_period_err;
    logic                o_x8_err;
    logic                o_lock;
    logic [15:0]         o_frame_cnt;

    modport master (
        output i_fram_hd_25us, i_time_delay_set, i_dly_fram_hd_25us,
               i_dly_x8hd_25us, i_dly_data_25us, i_clr,
        input  o_fram_hd_25us, o_x8hd_25us, o_data_25us, o_meas_delay,
               o_meas_valid, o_delay_err, o_period_err, o_x8_err,
               o_lock, o_frame_cnt
    );

    modport slave (
        input  i_fram_hd_25us, i_time_delay_set, i_dly_fram_hd_25us,
               i_dly_x8hd_25us, i_dly_data_25us, i_clr,
        output o_fram_hd_25us, o_x8hd_25us, o_data_25us, o_meas_delay,
               o_meas_valid, o_delay_err, o_period_err, o_x8_err,
               o_lock, o_frame_cnt
    );

endinterface

// File: rtl/lte_period_chk.sv
// Generic strobe-period checker. Counts cycles since the last strobe or
// restart; flags a strobe at the wrong distance, a restart without a
// coincident strobe, and a timeout once the count passes P_PERIOD.
module lte_period_chk #(
    parameter int unsigned P_PERIOD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic restart,   // phase restart, strobe must coincide with it
    output logic err,       // interval/coincidence error, combinational pulse
    output logic tmo        // single-cycle timeout pulse at count P_PERIOD+1
);
    localparam int unsigned W = $clog2(P_PERIOD + 3);

    logic [W-1:0] cnt;
    logic         armed;

    // cnt = cycles since last event; saturates just past the timeout point
    // so the timeout fires once per missing strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (strobe || restart) begin
            cnt   <= W'(1);
            armed <= 1'b1;
        end else if (cnt != W'(P_PERIOD + 2)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign err = armed & ((restart & ~strobe) |
                          (strobe & ~restart & (cnt != W'(P_PERIOD))));
    assign tmo = armed & ~strobe & ~restart & (cnt == W'(P_PERIOD + 1));

endmodule

// File: rtl/lte_delay_monitor.sv
// Checker for the LTE 25 us delay stage: measures reference-to-delayed head
// distance, checks frame and x8 cadence, runs SEARCH/CHECK/LOCK and forwards
// the stream with data gated until lock.
module lte_delay_monitor
    import lte_dp_pkg::*;
#(
    parameter int unsigned P_FRAME_CYC = FRAME_CYC_DEF,
    parameter int unsigned P_X8_CYC    = X8_CYC_DEF,
    parameter int unsigned P_DLY_OFS   = DLY_OFS_DEF,
    parameter int unsigned P_LOCK_N    = 3
) (
    input  logic                clk,
    input  logic                asy_rst_n,
    lte_delay_monitor_if.slave  bus
);
    localparam logic [DLY_W-1:0] DCNT_MAX = '1;

    mon_state_e       state;
    logic [3:0]       good;
    logic [DLY_W-1:0] dcnt, set_q, meas, exp_d;
    logic             hd, ref_hd;
    logic             f_err, f_tmo, x_err, x_tmo;
    logic             dly_bad, per_bad, x8_bad, active, any_err, done_lock;
    logic [7:0]       unused_set_hi;

    assign hd            = bus.i_dly_fram_hd_25us;
    assign ref_hd        = bus.i_fram_hd_25us;
    assign unused_set_hi = bus.i_time_delay_set[31:24];

    lte_period_chk #(.P_PERIOD(P_FRAME_CYC)) u_fram_chk (
        .clk(clk), .rst_n(asy_rst_n), .strobe(hd), .restart(1'b0),
        .err(f_err), .tmo(f_tmo)
    );

    // x8 phase is re-anchored on every delayed frame head.
    lte_period_chk #(.P_PERIOD(P_X8_CYC)) u_x8_chk (
        .clk(clk), .rst_n(asy_rst_n), .strobe(bus.i_dly_x8hd_25us), .restart(hd),
        .err(x_err), .tmo(x_tmo)
    );

    // Same-cycle reference uses the set value on the bus, not the stale latch.
    assign meas      = ref_hd ? '0 : ((dcnt == DCNT_MAX) ? DCNT_MAX : dcnt + DLY_W'(1));
    assign exp_d     = exp_delay(ref_hd ? bus.i_time_delay_set[DLY_W-1:0] : set_q, P_DLY_OFS);
    assign dly_bad   = hd & (meas != exp_d);
    assign per_bad   = f_err | f_tmo;
    assign x8_bad    = x_err | x_tmo;
    assign active    = (state != ST_SEARCH);
    assign any_err   = active & (dly_bad | per_bad | x8_bad);
    assign done_lock = (state == ST_CHECK) & hd & ~any_err & (good == 4'(P_LOCK_N - 1));

    // Delay counter and delay-setting latch, both anchored on the reference head.
    always_ff @(posedge clk or negedge asy_rst_n) begin
        if (!asy_rst_n) begin
            dcnt  <= '0;
            set_q <= '0;
        end else if (ref_hd) begin
            dcnt  <= '0;
            set_q <= bus.i_time_delay_set[DLY_W-1:0];
        end else if (dcnt != DCNT_MAX) begin
            dcnt <= dcnt + DLY_W'(1);
        end
    end

    // Passthrough and measurement registers; data gated by the current lock.
    always_ff @(posedge clk or negedge asy_rst_n) begin
        if (!asy_rst_n) begin
            bus.o_fram_hd_25us <= 1'b0;
            bus.o_x8hd_25us    <= 1'b0;
            bus.o_data_25us    <= '0;
            bus.o_meas_delay   <= '0;
            bus.o_meas_valid   <= 1'b0;
        end else begin
            bus.o_fram_hd_25us <= hd;
            bus.o_x8hd_25us    <= bus.i_dly_x8hd_25us;
            bus.o_data_25us    <= bus.o_lock ? bus.i_dly_data_25us : '0;
            bus.o_meas_valid   <= hd;
            if (hd) bus.o_meas_delay <= meas;
        end
    end

    // Lock FSM with registered lock, sticky flags and frame counter.
    always_ff @(posedge clk or negedge asy_rst_n) begin
        if (!asy_rst_n) begin
            state            <= ST_SEARCH;
            good             <= '0;
            bus.o_lock       <= 1'b0;
            bus.o_delay_err  <= 1'b0;
            bus.o_period_err <= 1'b0;
            bus.o_x8_err     <= 1'b0;
            bus.o_frame_cnt  <= '0;
        end else begin
            unique case (state)
                ST_SEARCH: if (hd) begin
                    state <= ST_CHECK;
                    good  <= '0;
                end
                ST_CHECK: if (any_err) begin
                    state <= ST_SEARCH;
                end else if (done_lock) begin
                    state      <= ST_LOCK;
                    bus.o_lock <= 1'b1;
                end else if (hd) begin
                    good <= good + 4'd1;
                end
                ST_LOCK: if (any_err) begin
                    state      <= ST_SEARCH;
                    bus.o_lock <= 1'b0;
                end
                default: begin
                    state      <= ST_SEARCH;
                    bus.o_lock <= 1'b0;
                end
            endcase
            // A new error in the clear cycle still lands in the flag.
            bus.o_delay_err  <= (bus.o_delay_err  & ~bus.i_clr) | (active & dly_bad);
            bus.o_period_err <= (bus.o_period_err & ~bus.i_clr) | (active & per_bad);
            bus.o_x8_err     <= (bus.o_x8_err     & ~bus.i_clr) | (active & x8_bad);
            if (bus.i_clr)
                bus.o_frame_cnt <= '0;
            else if (hd && (state == ST_LOCK || done_lock))
                bus.o_frame_cnt <= bus.o_frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lte_delay_monitor.sv
// Directed bench for lte_delay_monitor with a shortened frame period.
module tb_lte_delay_monitor;
    localparam int FP = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #2 clk = ~clk;

    lte_delay_monitor_if bus();

    lte_delay_monitor #(
        .P_FRAME_CYC(FP), .P_X8_CYC(8), .P_DLY_OFS(9), .P_LOCK_N(3)
    ) dut (
        .clk(clk), .asy_rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic [31:0] set;
        int          dly;
        logic [23:0] meas;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    int n, D, drop_k, shift_k, skip_x8;
    int pass_cnt = 0, total_cnt = 0;
    logic [31:0] set_v;
    logic        clr_v;
    logic [33:0] last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
        else
            pass_cnt++;
    endtask

    function automatic int hdn(input int k);
        return D + k * FP;
    endfunction

    // Stream generator: everything is a function of the cycle index n.
    task automatic drive();
        int rel, k, ph;
        logic h, x;
        rel = n - D;
        h = 1'b0;
        x = 1'b0;
        if (rel >= 0) begin
            k  = rel / FP;
            ph = rel % FP;
            h  = (ph == 0 && k != drop_k && k != shift_k) || (ph == 1 && k == shift_k);
            x  = (ph % 8 == 0) && (rel != skip_x8);
        end
        bus.i_fram_hd_25us     = (n % FP == 0);
        bus.i_time_delay_set   = set_v;
        bus.i_clr              = clr_v;
        bus.i_dly_fram_hd_25us = h;
        bus.i_dly_x8hd_25us    = x;
        bus.i_dly_data_25us    = {2'(n), 32'(n) ^ 32'h5A5A_C3C3};
        last_data              = bus.i_dly_data_25us;
    endtask

    task automatic tick();
        drive();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int m);
        while (n <= m) tick();
    endtask

    task automatic idle_inputs();
        bus.i_fram_hd_25us     = 1'b0;
        bus.i_time_delay_set   = '0;
        bus.i_dly_fram_hd_25us = 1'b0;
        bus.i_dly_x8hd_25us    = 1'b0;
        bus.i_dly_data_25us    = '0;
        bus.i_clr              = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        clr_v = 1'b0;
        drop_k = -1; shift_k = -1; skip_x8 = -1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " lock"},     64'(bus.o_lock), 64'd0);
        chk({tag, " fcnt"},     64'(bus.o_frame_cnt), 64'd0);
        chk({tag, " meas"},     64'(bus.o_meas_delay), 64'd0);
        chk({tag, " mvalid"},   64'(bus.o_meas_valid), 64'd0);
        chk({tag, " data"},     64'(bus.o_data_25us), 64'd0);
        chk({tag, " heads"},    64'({bus.o_fram_hd_25us, bus.o_x8hd_25us}), 64'd0);
        chk({tag, " flags"},    64'({bus.o_delay_err, bus.o_period_err, bus.o_x8_err}), 64'd0);
    endtask

    initial begin
        vecs[0] = '{32'd100,        109, 24'd109, 1'b0};
        vecs[1] = '{32'd100,        110, 24'd110, 1'b1};
        vecs[2] = '{32'h00FF_FFF7,  0,   24'd0,   1'b0};
        vecs[3] = '{32'h00FF_FFFF,  8,   24'd8,   1'b0};
        vecs[4] = '{32'd5,          13,  24'd13,  1'b1};
        vecs[5] = '{32'hAB00_0190,  409, 24'd409, 1'b0};

        set_v = 32'd100;
        D = 109;
        do_reset();
        chk_all_zero("reset");

        // Table: second head is measured and checked; clear pulsed in the same
        // cycle (error must win) and again in the next (flag must drop).
        for (int i = 0; i < 6; i++) begin
            set_v = vecs[i].set;
            D     = vecs[i].dly;
            do_reset();
            run_to(D + FP - 1);
            clr_v = 1'b1;
            tick();
            chk("vec hd_out",  64'(bus.o_fram_hd_25us), 64'd1);
            chk("vec mvalid",  64'(bus.o_meas_valid),   64'd1);
            chk("vec meas",    64'(bus.o_meas_delay),   64'(vecs[i].meas));
            chk("vec dly_err", 64'(bus.o_delay_err),    64'(vecs[i].err));
            chk("vec per_err", 64'(bus.o_period_err),   64'd0);
            chk("vec lock",    64'(bus.o_lock),         64'd0);
            tick();
            chk("vec clr",     64'(bus.o_delay_err),    64'd0);
            chk("vec mvalid0", 64'(bus.o_meas_valid),   64'd0);
            clr_v = 1'b0;
        end

        // Lock acquisition: first head to CHECK, then three good heads.
        set_v = 32'd100;
        D = 109;
        do_reset();
        run_to(hdn(3) - 1);
        chk("acq lock0", 64'(bus.o_lock), 64'd0);
        chk("acq meas",  64'(bus.o_meas_delay), 64'd109);
        chk("acq flags", 64'({bus.o_delay_err, bus.o_period_err, bus.o_x8_err}), 64'd0);
        tick();
        chk("acq lock1", 64'(bus.o_lock), 64'd1);
        chk("acq fcnt",  64'(bus.o_frame_cnt), 64'd1);
        chk("acq gated", 64'(bus.o_data_25us), 64'd0);
        tick();
        chk("acq data",  64'(bus.o_data_25us), 64'(last_data));
        run_to(hdn(5));
        chk("acq fcnt3", 64'(bus.o_frame_cnt), 64'd3);

        // One head late by a cycle: delay error, unlock, relock after 1+3.
        shift_k = 6;
        run_to(hdn(6) + 1);
        chk("shift dly_err", 64'(bus.o_delay_err), 64'd1);
        chk("shift lock",    64'(bus.o_lock), 64'd0);
        chk("shift meas",    64'(bus.o_meas_delay), 64'd110);
        tick();
        chk("shift data0",   64'(bus.o_data_25us), 64'd0);
        run_to(hdn(10) - 1);
        chk("relock lock0",  64'(bus.o_lock), 64'd0);
        tick();
        chk("relock lock1",  64'(bus.o_lock), 64'd1);
        clr_v = 1'b1;
        tick();
        clr_v = 1'b0;
        chk("clr flags", 64'({bus.o_delay_err, bus.o_period_err, bus.o_x8_err}), 64'd0);
        chk("clr fcnt",  64'(bus.o_frame_cnt), 64'd0);

        // Dropped head: timeout one cycle past the frame period.
        drop_k = 12;
        run_to(hdn(11) + FP);
        chk("drop per0", 64'(bus.o_period_err), 64'd0);
        chk("drop lk1",  64'(bus.o_lock), 64'd1);
        tick();
        chk("drop per1", 64'(bus.o_period_err), 64'd1);
        chk("drop lk0",  64'(bus.o_lock), 64'd0);
        chk("drop other", 64'({bus.o_delay_err, bus.o_x8_err}), 64'd0);
        run_to(hdn(16));
        chk("drop relock", 64'(bus.o_lock), 64'd1);
        clr_v = 1'b1;
        tick();
        clr_v = 1'b0;

        // Missing x8 head mid-frame.
        skip_x8 = 17 * FP + 40;
        run_to(D + skip_x8);
        chk("x8 err0", 64'(bus.o_x8_err), 64'd0);
        tick();
        chk("x8 err1", 64'(bus.o_x8_err), 64'd1);
        chk("x8 lock", 64'(bus.o_lock), 64'd0);
        chk("x8 other", 64'({bus.o_delay_err, bus.o_period_err}), 64'd0);
        run_to(hdn(21));
        chk("x8 relock", 64'(bus.o_lock), 64'd1);

        // Asynchronous reset mid-frame while locked.
        run_to(hdn(21) + 200);
        chk("prerst lock", 64'(bus.o_lock), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async rst");
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        drop_k = -1; shift_k = -1; skip_x8 = -1;
        run_to(hdn(3) - 1);
        chk("post-rst lock0", 64'(bus.o_lock), 64'd0);
        tick();
        chk("post-rst lock1", 64'(bus.o_lock), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
